// File: rtl/traffic_pkg.sv
// Shared state codes, lamp indices and lamp decode for the traffic-light controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      S_GREEN = 3'd0,
      S_YEL1  = 3'd1,
      S_RED   = 3'd2,
      S_YEL2  = 3'd3,
      S_NIGHT = 3'd4
   } state_t;

   localparam int unsigned LD_GREEN  = 0;
   localparam int unsigned LD_YELLOW = 1;
   localparam int unsigned LD_RED    = 2;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Lamp pattern for a state; unknown codes show red, matching the recovery target.
   function automatic logic [0:2] lamps(input state_t s, input logic blink);
      logic [0:2] l;
      l = '0;
      case (s)
         S_GREEN:        l[LD_GREEN]  = 1'b1;
         S_YEL1, S_YEL2: l[LD_YELLOW] = 1'b1;
         S_NIGHT:        l[LD_YELLOW] = blink;
         default:        l[LD_RED]    = 1'b1;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_prescaler.sv
// Divides clk down to a one-cycle tick every DIV cycles.
module tick_prescaler #(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned    DW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0]  LAST = DW'(DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_nxt;

   // Next divider value: wrap at DIV-1.
   always_comb begin
      div_nxt = (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
   end

   // Tick is registered from the next count so it is high exactly while div_cnt==DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         tick    <= (div_nxt == LAST);
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic-light controller: green/yellow/red sequencing with pedestrian green
// shortening and a blinking-yellow night mode, paced by an internal tick prescaler.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned DIV         = 50_000_000,
   parameter int unsigned T_GREEN     = 10,
   parameter int unsigned T_GREEN_MIN = 3,
   parameter int unsigned T_YELLOW    = 2,
   parameter int unsigned T_RED       = 8,
   parameter int unsigned BLINK_T     = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ped_req,
   input  logic       night_en,
   output logic [0:2] ld,
   output logic [2:0] out_state,
   output logic       tick,
   output logic       ped_ack
);

   localparam int unsigned T_MAX = max2(max2(max2(T_GREEN, T_YELLOW), max2(T_RED, BLINK_T)),
                                        T_GREEN_MIN);
   localparam int unsigned CNT_W = $clog2(T_MAX + 1);

   localparam logic [CNT_W-1:0] G_END    = CNT_W'(T_GREEN - 1);
   localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(T_GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] Y_END    = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] R_END    = CNT_W'(T_RED - 1);
   localparam logic [CNT_W-1:0] B_END    = CNT_W'(BLINK_T - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] ph_cnt, ph_n;
   logic [CNT_W-1:0] bl_cnt, bl_n;
   logic             blink, blink_n;
   logic             ped_pend, pend_n;
   logic             ack_n;

   tick_prescaler #(.DIV(DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign out_state = state;

   // Next-state, phase/blink counters and pedestrian bookkeeping.
   always_comb begin
      state_n = state;
      ph_n    = ph_cnt;
      bl_n    = bl_cnt;
      blink_n = blink;
      pend_n  = ped_pend;
      ack_n   = 1'b0;

      case (state)
         S_GREEN: begin
            if (tick && (ph_cnt == G_END || (ped_pend && ph_cnt >= GMIN_END)))
               state_n = S_YEL1;
         end
         S_YEL1: begin
            if (tick && ph_cnt == Y_END) begin
               state_n = S_RED;
               ack_n   = ped_pend;
            end
         end
         S_RED: begin
            if (tick && ph_cnt == R_END)
               state_n = night_en ? S_NIGHT : S_YEL2;
         end
         S_YEL2: begin
            if (tick && ph_cnt == Y_END)
               state_n = S_GREEN;
         end
         S_NIGHT: begin
            if (tick && !night_en)
               state_n = S_RED;
         end
         default: state_n = S_RED;
      endcase

      // NIGHT keeps ph_cnt parked at 0; its pacing comes from the blink counter.
      if (state_n != state)
         ph_n = '0;
      else if (tick && state != S_NIGHT)
         ph_n = ph_cnt + CNT_W'(1);

      if (state_n != S_NIGHT) begin
         blink_n = 1'b1;
         bl_n    = '0;
      end else if (state == S_NIGHT && tick) begin
         if (bl_cnt == B_END) begin
            blink_n = ~blink;
            bl_n    = '0;
         end else begin
            bl_n = bl_cnt + CNT_W'(1);
         end
      end

      // Clear on RED entry is applied last so it wins over a same-cycle request.
      if (ped_req && state != S_RED && state != S_NIGHT)
         pend_n = 1'b1;
      if (state_n == S_RED && state != S_RED)
         pend_n = 1'b0;
   end

   // State, counters and registered outputs; lamps come from the next-state values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_RED;
         ph_cnt   <= '0;
         bl_cnt   <= '0;
         blink    <= 1'b1;
         ped_pend <= 1'b0;
         ped_ack  <= 1'b0;
         ld       <= 3'b001;
      end else begin
         state    <= state_n;
         ph_cnt   <= ph_n;
         bl_cnt   <= bl_n;
         blink    <= blink_n;
         ped_pend <= pend_n;
         ped_ack  <= ack_n;
         ld       <= lamps(state_n, blink_n);
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: expected per-cycle outputs are queued
// when a scenario starts; a negedge monitor pops and compares.
module tb_traffic_light_ctrl;

   typedef struct {
      int         tid;
      int         w;
      logic [2:0] st;
      logic [0:2] ld;
      logic       tk;
      logic       tk_chk;
      logic       ack;
   } exp_t;

   localparam logic [2:0] GR = 3'd0, Y1 = 3'd1, RD = 3'd2, Y2 = 3'd3, NT = 3'd4;
   localparam logic [0:2] L_G = 3'b100, L_Y = 3'b010, L_R = 3'b001, L_OFF = 3'b000;

   logic       clk;
   logic       rst_n, rst1_n;
   logic       ped, night, ped1, night1;
   logic [0:2] ld0, ld1;
   logic [2:0] st0, st1;
   logic       tk0, tk1, ack0, ack1;

   exp_t q0[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;
   int   cur_test = 0;
   int   win = 0;
   logic in_rst = 1'b0;

   traffic_light_ctrl #(
      .DIV(4), .T_GREEN(5), .T_GREEN_MIN(2), .T_YELLOW(2), .T_RED(3), .BLINK_T(1)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .ped_req(ped), .night_en(night),
      .ld(ld0), .out_state(st0), .tick(tk0), .ped_ack(ack0)
   );

   traffic_light_ctrl #(
      .DIV(1), .T_GREEN(5), .T_GREEN_MIN(2), .T_YELLOW(2), .T_RED(3), .BLINK_T(1)
   ) dut1 (
      .clk(clk), .rst_n(rst1_n), .ped_req(ped1), .night_en(night1),
      .ld(ld1), .out_state(st1), .tick(tk1), .ped_ack(ack1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input exp_t e, input logic [2:0] st, input logic [0:2] ld,
                        input logic tk, input logic ack);
      tests++;
      if (st !== e.st || ld !== e.ld || ack !== e.ack || (e.tk_chk && tk !== e.tk)) begin
         fails++;
         $display("FAIL t%0d_w%0d: got state=%0d ld=%b tick=%b ack=%b, want state=%0d ld=%b tick=%b ack=%b",
                  e.tid, e.w, st, ld, tk, ack, e.st, e.ld, e.tk, e.ack);
      end
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) check(q0.pop_front(), st0, ld0, tk0, ack0);
      if (q1.size() > 0) check(q1.pop_front(), st1, ld1, tk1, ack1);
   end

   // Queue n expected windows of one state; ack applies to the first window only.
   task automatic seg(input int qs, input logic [2:0] st, input logic [0:2] ld,
                      input int n, input logic ack_first);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.tid    = cur_test;
         e.w      = win;
         e.st     = st;
         e.ld     = ld;
         e.ack    = ack_first && (i == 0);
         e.tk_chk = !(qs == 1 && win == 0);
         if (in_rst)       e.tk = 1'b0;
         else if (qs == 0) e.tk = (win % 4 == 3);
         else              e.tk = (win >= 1);
         if (qs == 0) q0.push_back(e);
         else         q1.push_back(e);
         win++;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input int qs);
      int g;
      g = 0;
      while (((qs == 0) ? q0.size() : q1.size()) > 0 && g < 400) begin
         @(posedge clk);
         g++;
      end
      if (((qs == 0) ? q0.size() : q1.size()) > 0) begin
         tests++;
         fails++;
         $display("FAIL t%0d_drain: got %0d pending entries, want 0", cur_test,
                  (qs == 0) ? q0.size() : q1.size());
         if (qs == 0) q0.delete();
         else         q1.delete();
      end
      step(1);
   endtask

   task automatic reset0();
      rst_n = 1'b0;
      ped   = 1'b0;
      night = 1'b0;
      step(2);
      win    = 0;
      in_rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst1_n = 1'b0;
      ped = 1'b0; night = 1'b0; ped1 = 1'b0; night1 = 1'b0;
      step(1);

      // 1: idle full cycle
      cur_test = 1;
      reset0();
      seg(0, RD, L_R, 12, 0); seg(0, Y2, L_Y, 8, 0); seg(0, GR, L_G, 20, 0);
      seg(0, Y1, L_Y, 8, 0);  seg(0, RD, L_R, 12, 0);
      rst_n = 1'b1;
      drain(0);

      // 2: pedestrian pulse in first GREEN cycle shortens green, acked on RED entry
      cur_test = 2;
      reset0();
      seg(0, RD, L_R, 12, 0); seg(0, Y2, L_Y, 8, 0); seg(0, GR, L_G, 8, 0);
      seg(0, Y1, L_Y, 8, 0);  seg(0, RD, L_R, 12, 1); seg(0, Y2, L_Y, 8, 0);
      seg(0, GR, L_G, 20, 0); seg(0, Y1, L_Y, 8, 0);
      rst_n = 1'b1;
      step(20); ped = 1'b1;
      step(1);  ped = 1'b0;
      drain(0);

      // 3: request held only during RED is ignored
      cur_test = 3;
      reset0();
      seg(0, RD, L_R, 12, 0); seg(0, Y2, L_Y, 8, 0); seg(0, GR, L_G, 20, 0);
      seg(0, Y1, L_Y, 8, 0);  seg(0, RD, L_R, 4, 0);
      ped   = 1'b1;
      rst_n = 1'b1;
      step(12); ped = 1'b0;
      drain(0);

      // 4: night mode requested in GREEN, entered at RED end, blinks, exits to full RED
      cur_test = 4;
      reset0();
      seg(0, RD, L_R, 12, 0); seg(0, Y2, L_Y, 8, 0); seg(0, GR, L_G, 20, 0);
      seg(0, Y1, L_Y, 8, 0);  seg(0, RD, L_R, 12, 0);
      seg(0, NT, L_Y, 4, 0);  seg(0, NT, L_OFF, 4, 0); seg(0, NT, L_Y, 4, 0);
      seg(0, NT, L_OFF, 4, 0); seg(0, NT, L_Y, 4, 0);
      seg(0, RD, L_R, 12, 0); seg(0, Y2, L_Y, 8, 0); seg(0, GR, L_G, 2, 0);
      rst_n = 1'b1;
      step(24); night = 1'b1;
      step(52); night = 1'b0;
      drain(0);

      // 5: asynchronous reset in mid-YEL1, then a full RED from restart
      cur_test = 5;
      reset0();
      seg(0, RD, L_R, 12, 0); seg(0, Y2, L_Y, 8, 0); seg(0, GR, L_G, 20, 0);
      seg(0, Y1, L_Y, 2, 0);
      in_rst = 1'b1;
      seg(0, RD, L_R, 2, 0);
      in_rst = 1'b0;
      win = 0;
      seg(0, RD, L_R, 12, 0); seg(0, Y2, L_Y, 2, 0);
      rst_n = 1'b1;
      step(42);
      #2 rst_n = 1'b0;
      @(posedge clk);
      step(1); rst_n = 1'b1;
      drain(0);

      // 6: DIV=1 instance, 12-clk period and 2-clk shortened green
      cur_test = 6;
      win = 0;
      seg(1, RD, L_R, 4, 0); seg(1, Y2, L_Y, 2, 0); seg(1, GR, L_G, 5, 0);
      seg(1, Y1, L_Y, 2, 0); seg(1, RD, L_R, 3, 0); seg(1, Y2, L_Y, 2, 0);
      seg(1, GR, L_G, 2, 0); seg(1, Y1, L_Y, 2, 0); seg(1, RD, L_R, 3, 1);
      seg(1, Y2, L_Y, 2, 0); seg(1, GR, L_G, 5, 0); seg(1, Y1, L_Y, 2, 0);
      rst1_n = 1'b1;
      step(18); ped1 = 1'b1;
      step(1);  ped1 = 1'b0;
      drain(1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
